// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle main control: states, opcodes, ALUOp codes
// and the control bundle. The link field exists only with MULTICYCLE_BLEZAL_EN.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTCOMP = 4'd7,
    S_BEQEX  = 4'd8,
    S_JMP    = 4'd9,
    S_BLZ    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BLEZAL = 6'b000110;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_SEXT   = 2'b10;
  localparam logic [1:0] SRCB_SEXTSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [2:0] aluop;
    logic       instr_done;
`ifdef MULTICYCLE_BLEZAL_EN
    logic       link;
`endif
  } ctrl_t;

endpackage

// File: rtl/multicycle_outdec.sv
// Moore output decode: maps the current state (and lez while in BLZ) onto the
// datapath control bundle. Unlisted and unused states drive everything to 0.
module multicycle_outdec
  import multicycle_pkg::*;
(
  input  state_t i_state,
  input  logic   i_lez,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      // Branch target is precomputed here while the opcode is decoded.
      S_DECODE: begin
        o_ctrl.alusrcb = SRCB_SEXTSH;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_SEXT;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.memread = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_RTEXEC: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_REG;
        o_ctrl.aluop   = ALUOP_RTYPE;
      end
      S_RTCOMP: begin
        o_ctrl.regdst     = 1'b1;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alusrca     = 1'b1;
        o_ctrl.aluop       = ALUOP_SUB;
        o_ctrl.pcwritecond = 1'b1;
        o_ctrl.pcsource    = PCSRC_ALUOUT;
        o_ctrl.instr_done  = 1'b1;
      end
      S_JMP: begin
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.pcsource   = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_BLEZAL_EN
      // Branch-and-link: PC and $31 are both written only when rs<=0.
      S_BLZ: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.aluop      = ALUOP_SUB;
        o_ctrl.pcsource   = PCSRC_ALUOUT;
        o_ctrl.instr_done = 1'b1;
        o_ctrl.pcwrite    = i_lez;
        o_ctrl.regwrite   = i_lez;
        o_ctrl.link       = i_lez;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath (state register + next-state in
// this file, output decode in multicycle_outdec). Option: MULTICYCLE_BLEZAL_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            lez,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            memtoreg,
  output logic            regdst,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsource,
  output logic [2:0]      aluop,
  output logic            instr_done,
  output logic            illegal_op,
`ifdef MULTICYCLE_BLEZAL_EN
  output logic            link,
`endif
  output logic [ST_W-1:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW)) w_next = S_MEMADR;
        else if (opcode == OP_W'(OP_RTYPE))                   w_next = S_RTEXEC;
        else if (opcode == OP_W'(OP_BEQ))                     w_next = S_BEQEX;
        else if (opcode == OP_W'(OP_J))                       w_next = S_JMP;
`ifdef MULTICYCLE_BLEZAL_EN
        else if (opcode == OP_W'(OP_BLEZAL))                  w_next = S_BLZ;
`endif
        else begin
          // Unsupported opcode: drop it; PC was already advanced in FETCH.
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      // IR is stable across the instruction, so the opcode is simply re-read here.
      S_MEMADR: w_next = (opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEXEC: w_next = S_RTCOMP;
      default:  w_next = S_FETCH;
    endcase
  end

  multicycle_outdec u_outdec (
    .i_state (r_state),
    .i_lez   (lez),
    .o_ctrl  (w_ctrl)
  );

  // Reset masks every output combinationally so strobes drop the moment it rises.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = 3'b000;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
`ifdef MULTICYCLE_BLEZAL_EN
    link        = 1'b0;
`endif
    state       = '0;
    if (!reset) begin
      pcwrite     = w_ctrl.pcwrite;
      pcwritecond = w_ctrl.pcwritecond;
      iord        = w_ctrl.iord;
      memread     = w_ctrl.memread;
      memwrite    = w_ctrl.memwrite;
      irwrite     = w_ctrl.irwrite;
      memtoreg    = w_ctrl.memtoreg;
      regdst      = w_ctrl.regdst;
      regwrite    = w_ctrl.regwrite;
      alusrca     = w_ctrl.alusrca;
      alusrcb     = w_ctrl.alusrcb;
      pcsource    = w_ctrl.pcsource;
      aluop       = w_ctrl.aluop;
      instr_done  = w_ctrl.instr_done;
      illegal_op  = w_illegal;
`ifdef MULTICYCLE_BLEZAL_EN
      link        = w_ctrl.link;
`endif
      state       = ST_W'(r_state);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output snapshots are
// queued when the opcode is driven and compared cycle by cycle.
module tb_multicycle_control;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       lez = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, instr_done, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;
  logic       w_link;

  logic [W-1:0] exp_q[$];
  int           err_cnt = 0;
  int           chk_cnt = 0;

  always #5 clk = ~clk;

`ifdef MULTICYCLE_BLEZAL_EN
  logic link;
  assign w_link = link;
`else
  assign w_link = 1'b0;
`endif

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .lez         (lez),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsource    (pcsource),
    .aluop       (aluop),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
`ifdef MULTICYCLE_BLEZAL_EN
    .link        (link),
`endif
    .state       (state)
  );

  // Snapshot layout: {link, state, pcwrite, pcwritecond, iord, memread, memwrite,
  // irwrite, memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource, aluop, done, illegal}
  function automatic logic [W-1:0] obs();
    return {w_link, state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
            memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource, aluop,
            instr_done, illegal_op};
  endfunction

  // str = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca}
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [9:0] str,
                                      input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic [2:0] aop, input logic done,
                                      input logic ill, input logic lnk);
    return {lnk, st, str, asb, pcs, aop, done, ill};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MULTICYCLE_BLEZAL_EN
      6'b000110: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_instr(input logic [5:0] op, input logic lz);
    exp_q.push_back(mk(4'd0, 10'b1001010000, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd1, 10'b0000000000, 2'b11, 2'b00, 3'b000, 1'b0, !is_legal(op), 1'b0));
    case (op)
      6'b100011: begin
        exp_q.push_back(mk(4'd2, 10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd3, 10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd4, 10'b0000001010, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0));
      end
      6'b101011: begin
        exp_q.push_back(mk(4'd2, 10'b0000000001, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd5, 10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0));
      end
      6'b000000: begin
        exp_q.push_back(mk(4'd6, 10'b0000000001, 2'b00, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'd7, 10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0));
      end
      6'b000100:
        exp_q.push_back(mk(4'd8, 10'b0100000001, 2'b00, 2'b01, 3'b001, 1'b1, 1'b0, 1'b0));
      6'b000010:
        exp_q.push_back(mk(4'd9, 10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0));
`ifdef MULTICYCLE_BLEZAL_EN
      6'b000110:
        exp_q.push_back(mk(4'd10, {lz, 7'b0000000, lz, 1'b1}, 2'b00, 2'b01, 3'b001, 1'b1, 1'b0, lz));
`endif
      default: ;
    endcase
  endtask

  // Called right after a falling edge; samples mid-low-phase, then waits for the next falling edge.
  task automatic step(input string tag);
    logic [W-1:0] e;
    #1;
    e = exp_q.pop_front();
    check(tag, obs(), e);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic lz, input string tag);
    opcode = op;
    lez    = lz;
    push_instr(op, lz);
    while (exp_q.size() > 0) step(tag);
  endtask

  initial begin
    logic [5:0] op_tbl[8];
    op_tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
               6'b000010, 6'b000110, 6'b111111, 6'b010101};

    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      exp_q.push_back('0);
      check("reset_hold", obs(), exp_q.pop_front());
    end
    reset = 1'b0;

    run_instr(6'b100011, 1'b0, "lw");
    run_instr(6'b000000, 1'b0, "rtype");
    run_instr(6'b101011, 1'b0, "sw");
    run_instr(6'b000100, 1'b0, "beq");
    run_instr(6'b000010, 1'b0, "j");
    run_instr(6'b111111, 1'b0, "illegal");
    run_instr(6'b000110, 1'b1, "blezal_lez1");
    run_instr(6'b000110, 1'b0, "blezal_lez0");

    // Reset in MEMRD: outputs must drop at once and MEMWB must never appear.
    opcode = 6'b100011;
    push_instr(6'b100011, 1'b0);
    repeat (3) step("lw_abort");
    #1;
    check("lw_abort_memrd", obs(), exp_q.pop_front());
    exp_q.delete();
    #2 reset = 1'b1;
    #1;
    exp_q.push_back('0);
    check("async_reset", obs(), exp_q.pop_front());
    @(negedge clk);
    #1;
    exp_q.push_back('0);
    check("reset_after_edge", obs(), exp_q.pop_front());
    reset = 1'b0;
    run_instr(6'b000010, 1'b0, "after_abort");

    for (int i = 0; i < 30; i++) begin
      logic [5:0] op;
      op = (i % 4 == 3) ? 6'($urandom_range(0, 63)) : op_tbl[$urandom_range(0, 7)];
      run_instr(op, 1'($urandom_range(0, 1)), "random");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
